// File: rtl/timekeeper_pkg.sv
// Shared encodings, field moduli and the 12 h display conversion for the time-of-day datapath.
package timekeeper_pkg;

  localparam logic [1:0] SEL_SUB  = 2'd0;
  localparam logic [1:0] SEL_SEC  = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_HOUR = 2'd3;

  localparam int unsigned SEC_MAX = 60;
  localparam int unsigned MIN_MAX = 60;

  // 0 -> 12, 1..12 unchanged, 13..23 -> hour-12.
  function automatic logic [4:0] to_12h(input logic [4:0] h);
    if (h == 5'd0) begin
      return 5'd12;
    end else if (h > 5'd12) begin
      return h - 5'd12;
    end
    return h;
  endfunction

endpackage

// File: rtl/timekeeper_dp_if.sv
// Control/status bundle between the watch control unit, the datapath and the FND controller.
interface timekeeper_dp_if #(
  parameter int unsigned TICK_HZ = 100
);
  localparam int unsigned SW = $clog2(TICK_HZ);

  logic          run;
  logic          clear;
  logic [1:0]    sel;
  logic          inc;
  logic          dec;
  logic          load_valid;
  logic [4:0]    load_hour;
  logic [5:0]    load_min;
  logic [5:0]    load_sec;
  logic          alarm_en;
  logic [4:0]    alarm_hour;
  logic [5:0]    alarm_min;
  logic          fmt12;
  logic [SW-1:0] sub;
  logic [5:0]    sec;
  logic [5:0]    min;
  logic [4:0]    hour;
  logic [4:0]    disp_hour;
  logic          pm;
  logic          day_tick;
  logic          alarm_hit;
  logic          load_err;

  modport master (
    output run, clear, sel, inc, dec, load_valid, load_hour, load_min, load_sec,
           alarm_en, alarm_hour, alarm_min, fmt12,
    input  sub, sec, min, hour, disp_hour, pm, day_tick, alarm_hit, load_err
  );

  modport slave (
    input  run, clear, sel, inc, dec, load_valid, load_hour, load_min, load_sec,
           alarm_en, alarm_hour, alarm_min, fmt12,
    output sub, sec, min, hour, disp_hour, pm, day_tick, alarm_hit, load_err
  );

endinterface

// File: rtl/time_field.sv
// One modulo-MOD time field: clear > load > adjust > carry-in count, with combinational carry-out.
module time_field #(
  parameter int unsigned MOD   = 60,
  parameter int unsigned WIDTH = 6,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             carry_in_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             block_carry_i,
  output logic [WIDTH-1:0] value_o,
  output logic             carry_out_o
);

  logic [WIDTH-1:0] value_q, value_d;
  logic             at_max;
  logic             at_zero;

  assign at_max      = (value_q == WIDTH'(MOD - 1));
  assign at_zero     = (value_q == '0);
  assign carry_out_o = carry_in_i & at_max & ~block_carry_i;
  assign value_o     = value_q;

  always_comb begin
    value_d = value_q;
    if (clear_i) begin
      value_d = WIDTH'(INIT);
    end else if (load_i) begin
      value_d = load_val_i;
    end else if (inc_i || (carry_in_i && !dec_i)) begin
      value_d = at_max ? '0 : value_q + WIDTH'(1);
    end else if (dec_i) begin
      value_d = at_zero ? WIDTH'(MOD - 1) : value_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= WIDTH'(INIT);
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/timekeeper_dp.sv
// Time-of-day datapath: prescaler, sub/sec/min/hour cascade, adjust, load, alarm and 12 h display.
module timekeeper_dp
  import timekeeper_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned HOUR_MAX  = 24,
  parameter int unsigned HOUR_INIT = 12
) (
  input logic             clk,
  input logic             rst,
  timekeeper_dp_if.slave  bus
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW  = $clog2(TICK_HZ);

  logic [PW-1:0] presc_q, presc_d;
  logic          day_tick_q, alarm_hit_q, load_err_q;
  logic          tick, cnt_tick, load_ok, adj_en, alarm_d;
  logic [3:0]    adj_sel, adj_inc, adj_dec;
  logic          sub_co, sec_co, min_co, hour_co;
  logic [SW-1:0] sub_v;
  logic [5:0]    sec_v, min_v, min_nxt;
  logic [4:0]    hour_v, hour_nxt;

  assign load_ok = bus.load_valid && (32'(bus.load_hour) < HOUR_MAX) &&
                   (32'(bus.load_min) < MIN_MAX) && (32'(bus.load_sec) < SEC_MAX);
  assign adj_en  = (bus.inc ^ bus.dec) & ~bus.load_valid & ~bus.clear;

  always_comb begin
    adj_sel = '0;
    adj_sel[bus.sel] = adj_en;
    adj_inc = adj_sel & {4{bus.inc}};
    adj_dec = adj_sel & {4{bus.dec}};
  end

  assign tick     = bus.run && (presc_q == PW'(DIV - 1));
  assign cnt_tick = tick & ~bus.clear & ~load_ok;

  always_comb begin
    presc_d = presc_q;
    if (bus.clear || load_ok) begin
      presc_d = '0;
    end else if (bus.run) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  time_field #(.MOD(TICK_HZ), .WIDTH(SW), .INIT(0)) u_sub (
    .clk(clk), .rst(rst), .carry_in_i(cnt_tick), .inc_i(adj_inc[SEL_SUB]),
    .dec_i(adj_dec[SEL_SUB]), .clear_i(bus.clear), .load_i(load_ok), .load_val_i('0),
    .block_carry_i(adj_sel[SEL_SUB]), .value_o(sub_v), .carry_out_o(sub_co)
  );

  time_field #(.MOD(SEC_MAX), .WIDTH(6), .INIT(0)) u_sec (
    .clk(clk), .rst(rst), .carry_in_i(sub_co), .inc_i(adj_inc[SEL_SEC]),
    .dec_i(adj_dec[SEL_SEC]), .clear_i(bus.clear), .load_i(load_ok),
    .load_val_i(bus.load_sec), .block_carry_i(adj_sel[SEL_SEC]), .value_o(sec_v),
    .carry_out_o(sec_co)
  );

  time_field #(.MOD(MIN_MAX), .WIDTH(6), .INIT(0)) u_min (
    .clk(clk), .rst(rst), .carry_in_i(sec_co), .inc_i(adj_inc[SEL_MIN]),
    .dec_i(adj_dec[SEL_MIN]), .clear_i(bus.clear), .load_i(load_ok),
    .load_val_i(bus.load_min), .block_carry_i(adj_sel[SEL_MIN]), .value_o(min_v),
    .carry_out_o(min_co)
  );

  time_field #(.MOD(HOUR_MAX), .WIDTH(5), .INIT(HOUR_INIT)) u_hour (
    .clk(clk), .rst(rst), .carry_in_i(min_co), .inc_i(adj_inc[SEL_HOUR]),
    .dec_i(adj_dec[SEL_HOUR]), .clear_i(bus.clear), .load_i(load_ok),
    .load_val_i(bus.load_hour), .block_carry_i(adj_sel[SEL_HOUR]), .value_o(hour_v),
    .carry_out_o(hour_co)
  );

  // Predict min/hour after a seconds carry so the alarm pulse lines up with the new time.
  assign min_nxt  = min_co ? 6'd0 : min_v + 6'd1;
  assign hour_nxt = min_co ? (hour_co ? 5'd0 : hour_v + 5'd1) : hour_v;
  assign alarm_d  = bus.alarm_en & sec_co & ~adj_sel[SEL_MIN] & ~adj_sel[SEL_HOUR] &
                    (min_nxt == bus.alarm_min) & (hour_nxt == bus.alarm_hour);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q     <= '0;
      day_tick_q  <= 1'b0;
      alarm_hit_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      day_tick_q  <= hour_co;
      alarm_hit_q <= alarm_d;
      load_err_q  <= bus.load_valid & ~load_ok & ~bus.clear;
    end
  end

  assign bus.sub       = sub_v;
  assign bus.sec       = sec_v;
  assign bus.min       = min_v;
  assign bus.hour      = hour_v;
  assign bus.day_tick  = day_tick_q;
  assign bus.alarm_hit = alarm_hit_q;
  assign bus.load_err  = load_err_q;
  assign bus.disp_hour = (bus.fmt12 && HOUR_MAX == 24) ? to_12h(hour_v) : hour_v;
  assign bus.pm        = (HOUR_MAX == 24) && (hour_v >= 5'd12);

endmodule

// File: tb/tb_timekeeper_dp.sv
// Scoreboard bench for timekeeper_dp with CLK_HZ=1000, TICK_HZ=10 (100 clocks per tick).
module tb_timekeeper_dp;

  logic clk = 1'b0;
  logic rst = 1'b1;

  timekeeper_dp_if #(.TICK_HZ(10)) bus ();

  timekeeper_dp #(
    .CLK_HZ(1000), .TICK_HZ(10), .HOUR_MAX(24), .HOUR_INIT(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sub;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
    logic       dt;
    logic       ah;
    logic       le;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int h, input int m, input int s, input int sb,
                         input bit dt, input bit ah, input bit le);
    exp_t e;
    e.hour = 5'(h); e.min = 6'(m); e.sec = 6'(s); e.sub = 4'(sb);
    e.dt = dt; e.ah = ah; e.le = le;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    check({tag, ".hour"},  bus.hour,      e.hour);
    check({tag, ".min"},   bus.min,       e.min);
    check({tag, ".sec"},   bus.sec,       e.sec);
    check({tag, ".sub"},   bus.sub,       e.sub);
    check({tag, ".dtick"}, bus.day_tick,  e.dt);
    check({tag, ".alarm"}, bus.alarm_hit, e.ah);
    check({tag, ".lerr"},  bus.load_err,  e.le);
  endtask

  task automatic do_load(input int h, input int m, input int s);
    bus.load_hour = 5'(h); bus.load_min = 6'(m); bus.load_sec = 6'(s);
    bus.load_valid = 1'b1;
    step(1);
    bus.load_valid = 1'b0;
  endtask

  task automatic do_adj(input int sel, input bit inc, input bit dec);
    bus.sel = 2'(sel); bus.inc = inc; bus.dec = dec;
    step(1);
    bus.inc = 1'b0; bus.dec = 1'b0;
  endtask

  // Frozen load of h:m:s followed by 9 sub increments, leaving the prescaler at 0.
  task automatic preset_sub9(input int h, input int m, input int s);
    bus.run = 1'b0;
    do_load(h, m, s);
    for (int i = 0; i < 9; i++) do_adj(0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.run = 0; bus.clear = 0; bus.sel = 0; bus.inc = 0; bus.dec = 0;
    bus.load_valid = 0; bus.load_hour = 0; bus.load_min = 0; bus.load_sec = 0;
    bus.alarm_en = 0; bus.alarm_hour = 0; bus.alarm_min = 0; bus.fmt12 = 0;

    sb_push(12, 0, 0, 0, 0, 0, 0);
    step(2);
    sb_check("reset");
    check("reset.disp", bus.disp_hour, 12);
    check("reset.pm",   bus.pm,        1);

    rst = 1'b0; bus.run = 1'b1;
    sb_push(12, 0, 1, 0, 0, 0, 0);
    step(1000);
    sb_check("run1000");

    bus.run = 1'b0;
    do_load(5, 59, 0);
    sb_push(5, 59, 0, 0, 0, 0, 0);
    sb_check("load5_59");
    sb_push(5, 0, 0, 0, 0, 0, 0);
    do_adj(2, 1'b1, 1'b0);
    sb_check("min_inc_wrap");
    do_load(0, 10, 20);
    sb_push(23, 10, 20, 0, 0, 0, 0);
    do_adj(3, 1'b0, 1'b1);
    sb_check("hour_dec_wrap");
    check("disp24", bus.disp_hour, 23);
    sb_push(23, 10, 20, 0, 0, 0, 0);
    do_adj(3, 1'b1, 1'b1);
    sb_check("inc_and_dec");
    sb_push(23, 10, 20, 9, 0, 0, 0);
    do_adj(0, 1'b0, 1'b1);
    sb_check("sub_dec_wrap");
    sb_push(23, 10, 20, 0, 0, 0, 0);
    do_adj(0, 1'b1, 1'b0);
    sb_check("sub_inc_nocarry");

    sb_push(13, 45, 30, 0, 0, 0, 0);
    do_load(13, 45, 30);
    sb_check("load13_45_30");
    bus.fmt12 = 1'b1;
    #1;
    check("fmt12.disp", bus.disp_hour, 1);
    check("fmt12.pm",   bus.pm,        1);
    bus.fmt12 = 1'b0;
    sb_push(13, 45, 30, 0, 0, 0, 1);
    do_load(24, 0, 0);
    sb_check("load_bad_hour");
    sb_push(13, 45, 30, 0, 0, 0, 0);
    step(1);
    sb_check("load_err_clr");
    sb_push(13, 45, 30, 0, 0, 0, 1);
    do_load(1, 60, 0);
    sb_check("load_bad_min");

    preset_sub9(23, 59, 59);
    bus.run = 1'b1;
    sb_push(23, 59, 59, 9, 0, 0, 0);
    step(99);
    sb_check("pre_wrap");
    sb_push(0, 0, 0, 0, 1, 0, 0);
    step(1);
    sb_check("day_wrap");
    bus.fmt12 = 1'b1;
    #1;
    check("midnight.disp", bus.disp_hour, 12);
    check("midnight.pm",   bus.pm,        0);
    bus.fmt12 = 1'b0;
    sb_push(0, 0, 0, 0, 0, 0, 0);
    step(1);
    sb_check("day_tick_clr");

    bus.alarm_hour = 5'd7; bus.alarm_min = 6'd0; bus.alarm_en = 1'b1;
    preset_sub9(6, 59, 59);
    bus.run = 1'b1;
    sb_push(6, 59, 59, 9, 0, 0, 0);
    step(99);
    sb_check("pre_alarm");
    sb_push(7, 0, 0, 0, 0, 1, 0);
    step(1);
    sb_check("alarm_fire");
    sb_push(7, 0, 0, 0, 0, 0, 0);
    step(1);
    sb_check("alarm_clr");
    bus.run = 1'b0;
    sb_push(7, 0, 0, 0, 0, 0, 0);
    do_load(7, 0, 0);
    sb_check("alarm_load");
    sb_push(7, 0, 0, 0, 0, 0, 0);
    step(1);
    sb_check("alarm_load2");
    bus.alarm_en = 1'b0;

    preset_sub9(23, 59, 59);
    bus.run = 1'b1;
    step(99);
    bus.clear = 1'b1;
    bus.load_hour = 5'd1; bus.load_min = 6'd2; bus.load_sec = 6'd3; bus.load_valid = 1'b1;
    sb_push(12, 0, 0, 0, 0, 0, 0);
    step(1);
    bus.clear = 1'b0; bus.load_valid = 1'b0;
    sb_check("clear_prio");
    sb_push(12, 0, 0, 1, 0, 0, 0);
    step(150);
    sb_check("after_clear");
    bus.run = 1'b0;
    sb_push(12, 0, 0, 1, 0, 0, 0);
    step(500);
    sb_check("frozen");
    bus.run = 1'b1;
    sb_push(12, 0, 0, 1, 0, 0, 0);
    step(49);
    sb_check("resume49");
    sb_push(12, 0, 0, 2, 0, 0, 0);
    step(1);
    sb_check("resume50");

    step(37);
    rst = 1'b1;
    sb_push(12, 0, 0, 0, 0, 0, 0);
    step(1);
    sb_check("rst_mid");
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
